// File: rtl/alu_decoder_sync.sv
// Registered ALU register-window / action decoder with a multi-cycle action sequencer.
// Optional sticky error flag (nerr) when ALU_DECODER_SYNC_ERR_EN is defined.
module alu_decoder_sync #(
  parameter logic [4:0]  UNIT_BASE   = 5'b11000,
  parameter int          IDXW        = 3,
  parameter logic [15:0] ACT_MASK    = 16'h0086,
  parameter logic [15:0] LONG_MASK   = 16'h0080,
  parameter int          LONG_CYCLES = 4,
  localparam int         NREG        = 1 << IDXW
) (
  input  logic            clk,
  input  logic            rsthold,
  input  logic            t34,
  input  logic [4:0]      raddr,
  input  logic [4:0]      waddr,
  input  logic [3:0]      action,
  output logic            nalu_op,
  output logic [NREG-1:0] nread,
  output logic [NREG-1:0] nwrite,
  output logic [15:0]     naction,
  output logic            nwait,
`ifdef ALU_DECODER_SYNC_ERR_EN
  output logic            nerr,
`endif
  output logic            dbg_busy
);

  typedef enum logic {IDLE, BUSY} state_t;

  // cnt counts the cycles remaining after the current one, minus one
  localparam logic [3:0] CNT_INIT = (LONG_CYCLES > 1) ? 4'(LONG_CYCLES - 2) : 4'd0;

  state_t     state, state_d;
  logic [3:0] cnt, cnt_d;
  logic [3:0] code, code_d;
  logic [3:0] strobe_code;
  logic       strobe;
  logic       nwait_d;
  logic       read_hit, write_hit, alu_hit;
  logic       act_owned, act_long;

  assign read_hit  = !t34 && (raddr[4:IDXW] == UNIT_BASE[4:IDXW]);
  assign write_hit = !t34 && (waddr[4:IDXW] == UNIT_BASE[4:IDXW]);
  assign alu_hit   = !t34 && (raddr[4:3] == 2'b10);
  assign act_owned = !t34 && (action != 4'd0) && ACT_MASK[action];
  assign act_long  = LONG_MASK[action];
  assign dbg_busy  = (state == BUSY);

  always_comb begin
    state_d     = state;
    cnt_d       = cnt;
    code_d      = code;
    strobe      = 1'b0;
    strobe_code = action;
    nwait_d     = 1'b1;
    case (state)
      IDLE: begin
        if (act_owned) begin
          strobe = 1'b1;
          if (act_long && (LONG_CYCLES > 1)) begin
            state_d = BUSY;
            cnt_d   = CNT_INIT;
            code_d  = action;
            nwait_d = 1'b0;
          end
        end
      end
      BUSY: begin
        // New actions are dropped here regardless of t34
        strobe      = 1'b1;
        strobe_code = code;
        if (cnt == 4'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d   = cnt - 4'd1;
          nwait_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rsthold) begin
      state   <= IDLE;
      cnt     <= 4'd0;
      code    <= 4'd0;
      nalu_op <= 1'b1;
      nread   <= '1;
      nwrite  <= '1;
      naction <= '1;
      nwait   <= 1'b1;
    end else begin
      state   <= state_d;
      cnt     <= cnt_d;
      code    <= code_d;
      nalu_op <= !alu_hit;
      nread   <= read_hit  ? ~(NREG'(1) << raddr[IDXW-1:0]) : '1;
      nwrite  <= write_hit ? ~(NREG'(1) << waddr[IDXW-1:0]) : '1;
      naction <= strobe ? ~(16'd1 << strobe_code) : '1;
      nwait   <= nwait_d;
    end
  end

`ifdef ALU_DECODER_SYNC_ERR_EN
  logic err_d;
  assign err_d = ((state == BUSY) && act_owned) ||
                 (read_hit && write_hit && (raddr[IDXW-1:0] == waddr[IDXW-1:0]));

  always_ff @(posedge clk) begin
    if (rsthold)    nerr <= 1'b1;
    else if (err_d) nerr <= 1'b0;
  end
`endif

endmodule

// File: doc/alu_decoder_sync.md
Name: alu_decoder_sync

Overview:
- Parametrised, registered successor to the ALU address/action decoder.
- Decodes the unit's read/write register window on RADDR/WADDR and owned ACTION codes into active-low strobes, registered on the clock edge.
- Adds a multi-cycle action sequencer: owned "long" actions (e.g. SRU shifts) hold their strobe for a programmable number of cycles and assert a wait line to the control unit.
- Sits between the microcode field decoders and the ALU/SRU register file.

Parameters:
- UNIT_BASE, 5'b11000, base of the unit's register window; only the bits above the index field are compared.
- IDXW, 3, index field width; NREG = 2**IDXW registers decoded (legal 1..3).
- ACT_MASK, 16'h0086, owned action codes; bit n set means action n is decoded.
- LONG_MASK, 16'h0080, subset of ACT_MASK that are multi-cycle actions.
- LONG_CYCLES, 4, strobe length of a long action in cycles (legal 1..16).

Ports:
- clk  in  1  system clock, all state on rising edge
- rsthold  in  1  synchronous active-high reset
- t34  in  1  strobe qualifier; decode enabled only when low
- raddr  in  5  read address field
- waddr  in  5  write address field
- action  in  4  action field
- nalu_op  out  1  low when raddr[4:3]==2'b10 (ALU operation read)
- nread  out  NREG  one-hot-low read strobe, index raddr[IDXW-1:0]
- nwrite  out  NREG  one-hot-low write strobe, index waddr[IDXW-1:0]
- naction  out  16  one-hot-low action strobes; bits outside ACT_MASK tied high
- nwait  out  1  low while a long action has further cycles to run

Behaviour:
- All outputs are registered. Latency is 1 cycle: inputs sampled at edge k drive the outputs from edge k until edge k+1.
- Reset (rsthold high at an edge): all outputs high, FSM IDLE, cnt=0. Reset dominates every other event. Reset during BUSY aborts the action at that edge.
- Read hit: t34 low and raddr[4:IDXW]==UNIT_BASE[4:IDXW]; then nread[raddr[IDXW-1:0]] goes low for one cycle.
- Write hit: same rule using waddr and nwrite. Read and write hits are independent; both may be active in the same cycle.
- nalu_op: t34 low and raddr[4:3]==2'b10.
- Action 0 is never decoded (no-op). Short action: t34 low, ACT_MASK[action]=1, LONG_MASK[action]=0; naction[action] goes low for one cycle.
- FSM states: IDLE and BUSY, with cnt[3:0].
- IDLE, on an owned long action with t34 low:
  - naction[action] goes low.
  - If LONG_CYCLES>1: latch the code, set cnt=LONG_CYCLES-2, nwait low, go to BUSY.
  - If LONG_CYCLES=1: behaves as a short action; nwait stays high.
- BUSY:
  - naction[latched] stays low.
  - If cnt==0: nwait high this cycle (last cycle), then IDLE at the next edge.
  - Else cnt decrements; nwait stays low.
- BUSY runs independently of t34. Total strobe length is exactly LONG_CYCLES cycles. nwait is low for LONG_CYCLES-1 cycles, starting together with the strobe.
- Actions sampled while BUSY are ignored, both short and long. Register read/write decoding continues normally while BUSY.
- A new long action sampled on the last BUSY cycle (cnt==0) is also ignored. Back-to-back long actions require one IDLE sample between them.
- Unowned action codes and t34 high: no strobe. Any short strobe returns high at the next edge.

Optional Feature:
- Macro: ALU_DECODER_SYNC_ERR_EN.
- With the macro defined: adds output port nerr (1 bit, reset high), a registered sticky error flag cleared only by rsthold. nerr goes low at the edge that samples either:
  - an owned action with t34 low while BUSY (dropped action), or
  - a read hit and write hit to the same index in the same sample.
- Without the macro: the port and logic are absent, and dropped actions are silent.

Test Plan:
- Reset: hold rsthold 2 cycles with raddr=5'b11000, t34=0 -> all outputs high, nwait=1. Release -> nread[0]=0 one cycle later.
- Window decode: t34=0, raddr=5'b11101, waddr=5'b11010 for one cycle -> next cycle nread=8'hDF, nwrite=8'hFB; following cycle both 8'hFF. Repeat with t34=1 -> no strobes. raddr=5'b10xxx -> nalu_op=0.
- Short action: action=4'h1, then 4'h2, then 4'h3 (unowned) -> naction[1] low 1 cycle, naction[2] low 1 cycle, all high for 4'h3.
- Long action: action=4'h7 single cycle, LONG_CYCLES=4 -> naction[7] low cycles 1-4, nwait low cycles 1-3, high on 4. Extra action=4'h1 during cycle 2 -> ignored; with ALU_DECODER_SYNC_ERR_EN, nerr=0 from that edge until reset.
- Reset mid-action: assert rsthold on BUSY cycle 2 -> next cycle naction=16'hFFFF, nwait=1, FSM IDLE. New 4'h7 afterwards runs the full 4 cycles.
- Parameter sweep: IDXW=2, UNIT_BASE=5'b01100, LONG_CYCLES=1 -> raddr 5'b01111 gives nread=4'h7. Action 7 gives a 1-cycle strobe with nwait never low.
